// File: rtl/idex_operand_stage.sv
// idex_operand_stage
// ID/EX pipeline register that sits directly in front of the ALU.
// It captures decoded operands, register addresses and control bits from
// decode, extends the 16-bit immediate at capture time, resolves data
// hazards by forwarding from EX/MEM and MEM/WB, and signals load-use hazards
// back to decode.
//
// Optional feature macro: IDEX_FORWARD_EN
//   defined   -> forwarding muxes present; during a stall the stored rs/rt
//                data are refreshed with their forwarded values.
//   undefined -> operands come from stored data only; exmem_*/memwb_* are
//                ignored and stored data simply holds during a stall.
//
// Ports:
//   clk, rst                 rising-edge clock, async active-high reset
//   stall, flush             hold stage / squash stage into a bubble
//   in_*                     decoded instruction fields from decode
//   exmem_*, memwb_*         forwarding sources (write enable, rd, value)
//   alu_a, alu_b, alu_sel    ALU operands and operation select
//   store_data               forwarded rt value for stores
//   out_valid, out_rd        stage occupancy and registered destination
//   out_reg_write            registered write enable, qualified by out_valid
//   out_mem_read             registered load flag, qualified by out_valid
//   load_use_hazard          combinational request for decode to stall

`ifndef ALU_SEL_ADD
`define ALU_SEL_ADD 2'b00
`endif

module idex_operand_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_rs_data,
  input  logic [DATA_W-1:0] in_rt_data,
  input  logic [15:0]       in_imm,
  input  logic              in_sign_ext,
  input  logic              in_alu_src_imm,
  input  logic [1:0]        in_alu_sel,
  input  logic [REG_AW-1:0] in_rs_addr,
  input  logic [REG_AW-1:0] in_rt_addr,
  input  logic [REG_AW-1:0] in_rd_addr,
  input  logic              in_uses_rt,
  input  logic              in_reg_write,
  input  logic              in_mem_read,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [1:0]        alu_sel,
  output logic [DATA_W-1:0] store_data,
  output logic              out_valid,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic              load_use_hazard
);

  logic              valid_q;
  logic              reg_write_q;
  logic              mem_read_q;
  logic              alu_src_imm_q;
  logic [1:0]        alu_sel_q;
  logic [REG_AW-1:0] rs_addr_q;
  logic [REG_AW-1:0] rt_addr_q;
  logic [REG_AW-1:0] rd_q;
  logic [DATA_W-1:0] rs_data_q;
  logic [DATA_W-1:0] rt_data_q;
  logic [DATA_W-1:0] imm_q;

  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;

  // Immediate is widened before it is stored so the EX side only sees a
  // ready-to-use DATA_W operand.
  assign imm_ext = in_sign_ext ? {{(DATA_W-16){in_imm[15]}}, in_imm}
                               : {{(DATA_W-16){1'b0}}, in_imm};

`ifdef IDEX_FORWARD_EN
  // Operand forwarding from the registered source addresses. EX/MEM is the
  // younger producer so it wins over MEM/WB; register 0 is never forwarded.
  always_comb begin
    fwd_rs = rs_data_q;
    fwd_rt = rt_data_q;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs_addr_q))
      fwd_rs = exmem_result;
    else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs_addr_q))
      fwd_rs = memwb_result;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rt_addr_q))
      fwd_rt = exmem_result;
    else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rt_addr_q))
      fwd_rt = memwb_result;
  end
`else
  // Without forwarding the operands are exactly what was captured; the
  // forwarding inputs are folded into an intentionally unused net.
  assign fwd_rs = rs_data_q;
  assign fwd_rt = rt_data_q;
  logic unused_fwd;
  assign unused_fwd = ^{exmem_reg_write, exmem_rd, exmem_result,
                        memwb_reg_write, memwb_rd, memwb_result};
`endif

  // Stage register. Flush only needs to kill the control bits; data fields
  // are don't-care in a bubble. During a stall with forwarding enabled the
  // stored operands are refreshed so a producer retiring mid-stall is kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q       <= 1'b0;
      reg_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      alu_src_imm_q <= 1'b0;
      alu_sel_q     <= `ALU_SEL_ADD;
      rs_addr_q     <= '0;
      rt_addr_q     <= '0;
      rd_q          <= '0;
      rs_data_q     <= '0;
      rt_data_q     <= '0;
      imm_q         <= '0;
    end else if (flush) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      alu_sel_q   <= `ALU_SEL_ADD;
    end else if (stall) begin
`ifdef IDEX_FORWARD_EN
      rs_data_q <= fwd_rs;
      rt_data_q <= fwd_rt;
`endif
    end else begin
      valid_q       <= in_valid;
      reg_write_q   <= in_valid & in_reg_write;
      mem_read_q    <= in_valid & in_mem_read;
      alu_src_imm_q <= in_alu_src_imm;
      alu_sel_q     <= in_alu_sel;
      rs_addr_q     <= in_rs_addr;
      rt_addr_q     <= in_rt_addr;
      rd_q          <= in_rd_addr;
      rs_data_q     <= in_rs_data;
      rt_data_q     <= in_rt_data;
      imm_q         <= imm_ext;
    end
  end

  assign alu_a         = fwd_rs;
  assign alu_b         = alu_src_imm_q ? imm_q : fwd_rt;
  assign alu_sel       = alu_sel_q;
  assign store_data    = fwd_rt;
  assign out_valid     = valid_q;
  assign out_rd        = rd_q;
  assign out_reg_write = valid_q & reg_write_q;
  assign out_mem_read  = valid_q & mem_read_q;

  // A load in this stage cannot forward its data in time for the
  // instruction now in decode; decode stalls itself and flushes this stage.
  assign load_use_hazard = valid_q && mem_read_q && (rd_q != '0) &&
                           ((in_rs_addr == rd_q) ||
                            (in_uses_rt && (in_rt_addr == rd_q)));

endmodule

// File: tb/tb_idex_operand_stage.sv
// tb_idex_operand_stage
// Directed bench for idex_operand_stage. Stimulus pushes expected values,
// tagged with the cycle they belong to, into a scoreboard queue; a monitor
// samples the DUT on every falling edge and pops/compares due entries.
// Expectations that depend on forwarding follow IDEX_FORWARD_EN.

`ifndef ALU_SEL_ADD
`define ALU_SEL_ADD 2'b00
`endif

module tb_idex_operand_stage;

`ifdef IDEX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam int SIG_A = 0, SIG_B = 1, SIG_SEL = 2, SIG_SD = 3, SIG_VALID = 4,
                 SIG_RD = 5, SIG_RW = 6, SIG_MR = 7, SIG_HAZ = 8;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_rs_data = '0;
  logic [31:0] in_rt_data = '0;
  logic [15:0] in_imm = '0;
  logic        in_sign_ext = 1'b0;
  logic        in_alu_src_imm = 1'b0;
  logic [1:0]  in_alu_sel = '0;
  logic [4:0]  in_rs_addr = '0;
  logic [4:0]  in_rt_addr = '0;
  logic [4:0]  in_rd_addr = '0;
  logic        in_uses_rt = 1'b0;
  logic        in_reg_write = 1'b0;
  logic        in_mem_read = 1'b0;
  logic        exmem_reg_write = 1'b0;
  logic [4:0]  exmem_rd = '0;
  logic [31:0] exmem_result = '0;
  logic        memwb_reg_write = 1'b0;
  logic [4:0]  memwb_rd = '0;
  logic [31:0] memwb_result = '0;
  logic [31:0] alu_a, alu_b, store_data;
  logic [1:0]  alu_sel;
  logic        out_valid, out_reg_write, out_mem_read, load_use_hazard;
  logic [4:0]  out_rd;

  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  exp_t sb[$];

  idex_operand_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
    .in_imm(in_imm), .in_sign_ext(in_sign_ext), .in_alu_src_imm(in_alu_src_imm),
    .in_alu_sel(in_alu_sel), .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr),
    .in_rd_addr(in_rd_addr), .in_uses_rt(in_uses_rt), .in_reg_write(in_reg_write),
    .in_mem_read(in_mem_read), .exmem_reg_write(exmem_reg_write),
    .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
    .memwb_result(memwb_result), .alu_a(alu_a), .alu_b(alu_b),
    .alu_sel(alu_sel), .store_data(store_data), .out_valid(out_valid),
    .out_rd(out_rd), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .load_use_hazard(load_use_hazard)
  );

  // Free-running clock and cycle counter used to tag expectations.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: on each falling edge, compare every expectation due by now.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t        e;
      logic [31:0] act;
      e = sb.pop_front();
      case (e.sig)
        SIG_A:     act = alu_a;
        SIG_B:     act = alu_b;
        SIG_SEL:   act = {30'd0, alu_sel};
        SIG_SD:    act = store_data;
        SIG_VALID: act = {31'd0, out_valid};
        SIG_RD:    act = {27'd0, out_rd};
        SIG_RW:    act = {31'd0, out_reg_write};
        SIG_MR:    act = {31'd0, out_mem_read};
        default:   act = {31'd0, load_use_hazard};
      endcase
      checks++;
      if (act === e.val) passes++;
      else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.val);
    end
  end

  // Watchdog so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  // Push one expected value for the current cycle onto the scoreboard.
  task automatic checkOutput(input int sig, input logic [31:0] val, input string name);
    exp_t e;
    e.cyc = cyc; e.sig = sig; e.val = val; e.name = name;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] rsd, input logic [31:0] rtd,
                               input logic [15:0] imm, input logic se, input logic srci,
                               input logic [1:0] sel, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic urt, input logic rw,
                               input logic mr);
    in_valid = v; in_rs_data = rsd; in_rt_data = rtd; in_imm = imm;
    in_sign_ext = se; in_alu_src_imm = srci; in_alu_sel = sel;
    in_rs_addr = rs; in_rt_addr = rt; in_rd_addr = rd; in_uses_rt = urt;
    in_reg_write = rw; in_mem_read = mr;
  endtask

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  task automatic clearFwd();
    exmem_reg_write = 1'b0; exmem_rd = '0; exmem_result = '0;
    memwb_reg_write = 1'b0; memwb_rd = '0; memwb_result = '0;
  endtask

  initial begin
    // Reset state while rst is held.
    cycle(); cycle();
    checkOutput(SIG_VALID, 0, "rst_valid");
    checkOutput(SIG_SEL, `ALU_SEL_ADD, "rst_sel");
    checkOutput(SIG_A, 0, "rst_a");
    checkOutput(SIG_B, 0, "rst_b");
    checkOutput(SIG_SD, 0, "rst_sd");
    checkOutput(SIG_RD, 0, "rst_rd");
    checkOutput(SIG_RW, 0, "rst_rw");
    checkOutput(SIG_MR, 0, "rst_mr");
    checkOutput(SIG_HAZ, 0, "rst_haz");
    sample();
    rst = 1'b0;

    // Immediate capture, sign- and zero-extended.
    applyStimulus(1, 32'h10, 32'h55, 16'hFFFE, 1, 1, 2'b01, 1, 2, 4, 0, 1, 0);
    cycle();
    checkOutput(SIG_A, 32'h10, "sx_a");
    checkOutput(SIG_B, 32'hFFFF_FFFE, "sx_b");
    checkOutput(SIG_SEL, 2'b01, "sx_sel");
    checkOutput(SIG_SD, 32'h55, "sx_sd");
    checkOutput(SIG_VALID, 1, "sx_valid");
    checkOutput(SIG_RD, 4, "sx_rd");
    checkOutput(SIG_RW, 1, "sx_rw");
    checkOutput(SIG_MR, 0, "sx_mr");
    sample();
    in_sign_ext = 1'b0;
    cycle();
    checkOutput(SIG_B, 32'h0000_FFFE, "zx_b");
    sample();

    // Double forwarding hit on rs: EX/MEM wins, then MEM/WB, then reg 0.
    applyStimulus(1, 32'h11, 32'h22, 16'h0, 0, 0, 2'b00, 5, 6, 8, 1, 1, 0);
    cycle();
    exmem_reg_write = 1; exmem_rd = 5; exmem_result = 32'hAAAA;
    memwb_reg_write = 1; memwb_rd = 5; memwb_result = 32'hBBBB;
    checkOutput(SIG_A, FWD ? 32'hAAAA : 32'h11, "fwd_exmem_a");
    checkOutput(SIG_B, 32'h22, "fwd_nohit_b");
    checkOutput(SIG_HAZ, 0, "fwd_haz");
    sample();
    cycle();
    exmem_reg_write = 0;
    checkOutput(SIG_A, FWD ? 32'hBBBB : 32'h11, "fwd_memwb_a");
    sample();
    applyStimulus(1, 32'h33, 32'h22, 16'h0, 0, 0, 2'b00, 0, 6, 8, 1, 1, 0);
    exmem_reg_write = 1; exmem_rd = 0; memwb_rd = 0;
    cycle();
    checkOutput(SIG_A, 32'h33, "fwd_r0_a");
    sample();
    clearFwd();

    // Sticky forwarding across a stall.
    applyStimulus(1, 32'h1, 32'h99, 16'h0, 0, 0, 2'b00, 1, 7, 9, 1, 1, 0);
    cycle();
    checkOutput(SIG_B, 32'h99, "sticky_pre_b");
    checkOutput(SIG_SD, 32'h99, "sticky_pre_sd");
    sample();
    stall = 1;
    memwb_reg_write = 1; memwb_rd = 7; memwb_result = 32'h1234;
    applyStimulus(1, 32'hDEAD, 32'hBEEF, 16'h0, 0, 0, 2'b11, 1, 7, 12, 1, 1, 0);
    cycle();
    memwb_reg_write = 0;
    checkOutput(SIG_B, FWD ? 32'h1234 : 32'h99, "sticky_b1");
    checkOutput(SIG_SD, FWD ? 32'h1234 : 32'h99, "sticky_sd1");
    checkOutput(SIG_RD, 9, "sticky_rd");
    checkOutput(SIG_A, 32'h1, "sticky_a");
    checkOutput(SIG_SEL, 2'b00, "sticky_sel");
    sample();
    cycle();
    checkOutput(SIG_B, FWD ? 32'h1234 : 32'h99, "sticky_b2");
    checkOutput(SIG_SD, FWD ? 32'h1234 : 32'h99, "sticky_sd2");
    sample();
    stall = 0;
    clearFwd();

    // Load in stage, then load-use detection, then flush beating stall.
    applyStimulus(1, 32'h5, 32'h6, 16'h0, 0, 0, 2'b10, 10, 11, 3, 0, 1, 1);
    cycle();
    checkOutput(SIG_VALID, 1, "ld_valid");
    checkOutput(SIG_MR, 1, "ld_mr");
    checkOutput(SIG_RD, 3, "ld_rd");
    checkOutput(SIG_SEL, 2'b10, "ld_sel");
    checkOutput(SIG_HAZ, 0, "ld_nohaz");
    sample();
    stall = 1;
    applyStimulus(1, 32'h0, 32'h0, 16'h0, 0, 0, 2'b00, 1, 3, 4, 1, 1, 0);
    cycle();
    checkOutput(SIG_HAZ, 1, "lu_rt_haz");
    checkOutput(SIG_RD, 3, "lu_hold_rd");
    sample();
    in_uses_rt = 0;
    cycle();
    checkOutput(SIG_HAZ, 0, "lu_rt_unused");
    sample();
    in_rs_addr = 3;
    cycle();
    checkOutput(SIG_HAZ, 1, "lu_rs_haz");
    sample();
    flush = 1;
    cycle();
    checkOutput(SIG_VALID, 0, "flush_valid");
    checkOutput(SIG_MR, 0, "flush_mr");
    checkOutput(SIG_RW, 0, "flush_rw");
    checkOutput(SIG_HAZ, 0, "flush_haz");
    checkOutput(SIG_SEL, `ALU_SEL_ADD, "flush_sel");
    sample();
    flush = 0; stall = 0;

    // Load targeting r0 never raises a hazard.
    applyStimulus(1, 32'h0, 32'h0, 16'h0, 0, 0, 2'b00, 0, 0, 0, 1, 1, 1);
    cycle();
    checkOutput(SIG_MR, 1, "ld0_mr");
    checkOutput(SIG_HAZ, 0, "ld0_haz");
    sample();

    // Captured bubble (in_valid=0) has no write or load.
    applyStimulus(0, 32'h0, 32'h0, 16'h0, 0, 0, 2'b00, 6, 6, 6, 1, 1, 1);
    cycle();
    checkOutput(SIG_VALID, 0, "bub_valid");
    checkOutput(SIG_RW, 0, "bub_rw");
    checkOutput(SIG_MR, 0, "bub_mr");
    sample();

    // Asynchronous reset between edges, with stall also asserted.
    applyStimulus(1, 32'h77, 32'h88, 16'h1234, 0, 1, 2'b11, 2, 4, 5, 0, 1, 1);
    cycle();
    checkOutput(SIG_A, 32'h77, "pre_rst_a");
    checkOutput(SIG_B, 32'h1234, "pre_rst_b");
    checkOutput(SIG_SEL, 2'b11, "pre_rst_sel");
    sample();
    cycle();
    #1;
    rst = 1; stall = 1;
    #1;
    checks++;
    if (alu_a === 32'h0) passes++;
    else $display("[TB] FAIL arst_now_a: got 0x%0h expected 0x0", alu_a);
    checks++;
    if (alu_b === 32'h0) passes++;
    else $display("[TB] FAIL arst_now_b: got 0x%0h expected 0x0", alu_b);
    checks++;
    if (store_data === 32'h0) passes++;
    else $display("[TB] FAIL arst_now_sd: got 0x%0h expected 0x0", store_data);
    checks++;
    if (alu_sel === `ALU_SEL_ADD) passes++;
    else $display("[TB] FAIL arst_now_sel: got 0x%0h expected 0x%0h", alu_sel, `ALU_SEL_ADD);
    checks++;
    if (out_valid === 1'b0) passes++;
    else $display("[TB] FAIL arst_now_valid: got %0b expected 0", out_valid);
    checks++;
    if (out_rd === 5'd0) passes++;
    else $display("[TB] FAIL arst_now_rd: got 0x%0h expected 0x0", out_rd);
    checks++;
    if (load_use_hazard === 1'b0) passes++;
    else $display("[TB] FAIL arst_now_haz: got %0b expected 0", load_use_hazard);
    checkOutput(SIG_A, 0, "arst_a");
    checkOutput(SIG_B, 0, "arst_b");
    checkOutput(SIG_SD, 0, "arst_sd");
    checkOutput(SIG_SEL, `ALU_SEL_ADD, "arst_sel");
    checkOutput(SIG_VALID, 0, "arst_valid");
    checkOutput(SIG_RD, 0, "arst_rd");
    checkOutput(SIG_RW, 0, "arst_rw");
    checkOutput(SIG_MR, 0, "arst_mr");
    checkOutput(SIG_HAZ, 0, "arst_haz");
    sample();
    rst = 0; stall = 0;
    cycle(); sample();

    // Anything still queued was never compared.
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      $display("[TB] FAIL %s: never sampled, expected 0x%0h", e.name, e.val);
    end
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
